raycast_column_scheduler: RTL
=============================

Name: raycast_column_scheduler

Overview:
- Sequences the per-column slice-height engine across one frame: issues one begin_calc per screen column, waits for end_calc, and captures slice_size.
- Hands each result to the slice drawer through a valid/ready port.
- Latches player pose at frame start so the engine sees stable inputs for the whole frame.
- Sits between the game-state/frame-timing logic and the slice-height engine / VGA drawer.

Parameters:
- NUM_COLS, 160, columns per frame; legal range 1..256.
- HEIGHT_W, 7, slice height width.
- TIMEOUT_CYCLES, 1023, per-column watchdog limit; used only with TIMEOUT_EN.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle request to render a frame
- playerX, playerY  in  13 signed each  player position, sampled at frame_start
- angle_X, angle_Y  in  10 signed each  view angle, sampled at frame_start
- calc_playerX, calc_playerY  out  13 signed each  latched pose to engine
- calc_angle_X, calc_angle_Y  out  10 signed each  latched angle to engine
- column_count  out  8  current column index to engine
- begin_calc  out  1  one-cycle start pulse to engine
- end_calc  in  1  engine completion pulse
- slice_size  in  HEIGHT_W  engine result, valid when end_calc=1
- slice_valid  out  1  result available to drawer
- slice_column  out  8  column of the presented result
- slice_height  out  HEIGHT_W  height of the presented result
- slice_ready  in  1  drawer accepts the result
- frame_busy  out  1  high from the cycle after accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse when the last slice has been accepted
- timeout_err  out  1  sticky watchdog flag; exists only with TIMEOUT_EN

Behaviour:
- Reset (async, resetn=0): state=IDLE.
  - All outputs are 0: begin_calc, slice_valid, frame_busy, frame_done, timeout_err.
  - All registers are 0: column_count, slice_column, slice_height, latched pose.
- State IDLE:
  - frame_start=1 latches the pose, sets column_count=0, and goes to START.
  - begin_calc is asserted on the following cycle, i.e. 1 cycle after frame_start.
- State START:
  - begin_calc=1 for exactly one cycle, then go to WAIT_CALC.
- State WAIT_CALC:
  - On end_calc, capture slice_size and column_count into the pending register and go to PUSH.
  - end_calc seen in any other state is ignored.
- State PUSH:
  - Transfer pending to the output register when the output register is empty, or when it is draining this cycle (slice_valid & slice_ready).
  - On transfer, set slice_valid=1.
  - If column_count==NUM_COLS-1, go to DRAIN.
  - Otherwise increment column_count and go to START.
  - The next column's calculation therefore overlaps the drawer consuming the previous one.
- State DRAIN:
  - When slice_valid=0, or slice_valid & slice_ready, pulse frame_done for 1 cycle, clear frame_busy, and go to IDLE.
- Output handshake:
  - slice_valid, slice_column and slice_height are held stable until slice_ready.
  - slice_valid clears on acceptance unless refilled in the same cycle.
  - No result is ever dropped or duplicated; slices are presented in column order 0..NUM_COLS-1.
- frame_start while frame_busy=1 is ignored. No queuing.
- calc_* pose outputs change only on an accepted frame_start.
- With slice_ready held 1 and an engine latency of L cycles, per-column throughput is L+2 cycles.
- The column counter never wraps. For NUM_COLS=1, the first column goes straight to DRAIN.

Optional Feature:
- Macro: RAYCAST_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter resets on entry to WAIT_CALC.
  - If end_calc is not seen within TIMEOUT_CYCLES, slice_size=0 is captured for that column and the block proceeds as if end_calc had arrived.
  - timeout_err goes high and stays high until reset.
  - An end_calc arriving exactly on the timeout cycle counts as a normal completion.
- Without the macro: WAIT_CALC waits indefinitely, and the timeout_err port and counter do not exist.

Decomposition:
- Shared package raycast_pkg holds:
  - State encoding constants (IDLE, START, WAIT_CALC, PUSH, DRAIN).
  - SCREEN_COLS=160.
  - HEIGHT_W=7.
  - Pose width constants: POS_W=13, ANG_W=10.
- One sub-module: slice_out_reg, the single-entry valid/ready output holding register with simultaneous load/drain.

Test Plan:
- Basic frame: reset; frame_start with playerX=100, angle_X=45; engine model with 3-cycle latency returning height=col%128; slice_ready=1.
  - Expect 160 slices, columns 0..159 in order, with matching heights.
  - Expect begin_calc 1 cycle after frame_start and a single frame_done pulse.
- Backpressure: slice_ready toggled as 1 cycle high, 4 low.
  - slice_height and slice_column stay stable while unaccepted.
  - begin_calc for column n+2 waits until column n is accepted.
  - No loss or duplication.
- Pose latching: change playerX to 200 mid-frame and assert frame_start mid-frame.
  - calc_playerX stays 100 for the whole frame.
  - The second frame_start is ignored, with exactly one frame_done.
- Reset mid-frame: assert resetn=0 at column 57.
  - Outputs go to 0 immediately (asynchronously).
  - After release, frame_start restarts from column 0.
- Timeout (RAYCAST_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=20): engine never responds at column 5.
  - Column 5 is delivered with height 0 after 20 cycles.
  - timeout_err is 1 and stays sticky.
  - Columns 6..159 proceed normally.

Source files
------------

// File: rtl/raycast_column_scheduler_pkg.sv
// Shared constants and state encoding for the ray-cast column scheduler.
// Optional watchdog feature is enabled by defining RAYCAST_SCHED_TIMEOUT_EN.
package raycast_pkg;

  localparam int SCREEN_COLS = 160;
  localparam int HEIGHT_W    = 7;
  localparam int POS_W       = 13;
  localparam int ANG_W       = 10;
  localparam int COL_W       = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_CALC = 3'd2,
    PUSH      = 3'd3,
    DRAIN     = 3'd4
  } sched_state_t;

endpackage

// File: rtl/raycast_column_scheduler_slice_out_reg.sv
// Single-entry valid/ready holding register for finished slices.
// Accepts a new entry when empty or when the current one leaves this cycle.
module slice_out_reg
  import raycast_pkg::*;
#(
  parameter int HEIGHT_W = 7
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                load,
  input  logic [COL_W-1:0]    load_column,
  input  logic [HEIGHT_W-1:0] load_height,
  input  logic                ready,
  output logic                can_load,
  output logic                valid,
  output logic [COL_W-1:0]    column,
  output logic [HEIGHT_W-1:0] height
);

  // Room for a new entry: empty now, or the held entry is accepted this cycle
  always_comb begin
    can_load = ~valid | ready;
  end

  // Valid flag: set on load, cleared on acceptance unless refilled
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

  // Payload: only changes on load, so it stays stable while unaccepted
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      column <= {COL_W{1'b0}};
      height <= {HEIGHT_W{1'b0}};
    end else if (load) begin
      column <= load_column;
      height <= load_height;
    end else begin
      column <= column;
      height <= height;
    end
  end

endmodule

// File: rtl/raycast_column_scheduler.sv
// Frame-level sequencer for the per-column slice-height engine.
// Latches the pose at frame start, runs one engine calculation per column and
// hands results to the drawer through a one-entry valid/ready register so the
// next calculation overlaps the drawer consuming the previous result.
// Define RAYCAST_SCHED_TIMEOUT_EN to add the per-column watchdog and timeout_err.
module raycast_column_scheduler
  import raycast_pkg::*;
#(
  parameter int NUM_COLS = SCREEN_COLS,
  parameter int HEIGHT_W = raycast_pkg::HEIGHT_W
`ifdef RAYCAST_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    frame_start,
  input  logic signed [POS_W-1:0] playerX,
  input  logic signed [POS_W-1:0] playerY,
  input  logic signed [ANG_W-1:0] angle_X,
  input  logic signed [ANG_W-1:0] angle_Y,
  output logic signed [POS_W-1:0] calc_playerX,
  output logic signed [POS_W-1:0] calc_playerY,
  output logic signed [ANG_W-1:0] calc_angle_X,
  output logic signed [ANG_W-1:0] calc_angle_Y,
  output logic [COL_W-1:0]        column_count,
  output logic                    begin_calc,
  input  logic                    end_calc,
  input  logic [HEIGHT_W-1:0]     slice_size,
  output logic                    slice_valid,
  output logic [COL_W-1:0]        slice_column,
  output logic [HEIGHT_W-1:0]     slice_height,
  input  logic                    slice_ready,
  output logic                    frame_busy,
  output logic                    frame_done
`ifdef RAYCAST_SCHED_TIMEOUT_EN
  , output logic                  timeout_err
`endif
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  sched_state_t          state_r;
  sched_state_t          state_s;
  logic                  load_s;
  logic                  can_load_s;
  logic                  calc_done_s;
  logic [HEIGHT_W-1:0]   calc_height_s;
  logic [COL_W-1:0]      pend_col_r;
  logic [HEIGHT_W-1:0]   pend_height_r;

`ifdef RAYCAST_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);

  logic [WD_W-1:0] wd_r;
  logic            wd_expired_s;

  // Watchdog expiry; an end_calc on the final cycle still counts as normal
  always_comb begin
    wd_expired_s  = (state_r == WAIT_CALC) && !end_calc &&
                    (wd_r == WD_W'(TIMEOUT_CYCLES - 1));
    calc_done_s   = end_calc | wd_expired_s;
    calc_height_s = end_calc ? slice_size : {HEIGHT_W{1'b0}};
  end

  // Watchdog counter restarts on every entry to WAIT_CALC
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wd_r <= {WD_W{1'b0}};
    end else if (state_r == START) begin
      wd_r <= {WD_W{1'b0}};
    end else if (state_r == WAIT_CALC) begin
      wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      wd_r <= wd_r;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timeout_err <= 1'b0;
    end else if (wd_expired_s) begin
      timeout_err <= 1'b1;
    end else begin
      timeout_err <= timeout_err;
    end
  end
`else
  // Without the watchdog the engine result is the only completion source
  always_comb begin
    calc_done_s   = end_calc;
    calc_height_s = slice_size;
  end
`endif

  // Next-state decode and output-register load request
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_start) state_s = START;
        else             state_s = IDLE;
      end
      START: begin
        state_s = WAIT_CALC;
      end
      WAIT_CALC: begin
        if (calc_done_s) state_s = PUSH;
        else             state_s = WAIT_CALC;
      end
      PUSH: begin
        if (can_load_s) begin
          load_s = 1'b1;
          if (column_count == LAST_COL) state_s = DRAIN;
          else                          state_s = START;
        end else begin
          state_s = PUSH;
        end
      end
      DRAIN: begin
        if (can_load_s) state_s = IDLE;
        else            state_s = DRAIN;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered control outputs derived from next state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= IDLE;
      begin_calc <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      begin_calc <= (state_s == START);
      frame_busy <= (state_s != IDLE);
      frame_done <= (state_r == DRAIN) && (state_s == IDLE);
    end
  end

  // Pose is latched only when a frame request is accepted
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      calc_playerX <= {POS_W{1'b0}};
      calc_playerY <= {POS_W{1'b0}};
      calc_angle_X <= {ANG_W{1'b0}};
      calc_angle_Y <= {ANG_W{1'b0}};
    end else if ((state_r == IDLE) && frame_start) begin
      calc_playerX <= playerX;
      calc_playerY <= playerY;
      calc_angle_X <= angle_X;
      calc_angle_Y <= angle_Y;
    end else begin
      calc_playerX <= calc_playerX;
      calc_playerY <= calc_playerY;
      calc_angle_X <= calc_angle_X;
      calc_angle_Y <= calc_angle_Y;
    end
  end

  // Column index: cleared at frame start, advanced after each handoff, never wraps
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      column_count <= {COL_W{1'b0}};
    end else if ((state_r == IDLE) && frame_start) begin
      column_count <= {COL_W{1'b0}};
    end else if (load_s && (column_count != LAST_COL)) begin
      column_count <= column_count + 8'd1;
    end else begin
      column_count <= column_count;
    end
  end

  // Pending result captured when the engine (or watchdog) completes a column
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_col_r    <= {COL_W{1'b0}};
      pend_height_r <= {HEIGHT_W{1'b0}};
    end else if ((state_r == WAIT_CALC) && calc_done_s) begin
      pend_col_r    <= column_count;
      pend_height_r <= calc_height_s;
    end else begin
      pend_col_r    <= pend_col_r;
      pend_height_r <= pend_height_r;
    end
  end

  slice_out_reg #(
    .HEIGHT_W (HEIGHT_W)
  ) u_out (
    .clock       (clock),
    .resetn      (resetn),
    .load        (load_s),
    .load_column (pend_col_r),
    .load_height (pend_height_r),
    .ready       (slice_ready),
    .can_load    (can_load_s),
    .valid       (slice_valid),
    .column      (slice_column),
    .height      (slice_height)
  );

endmodule
